// File: rtl/mem_wb_stage.sv
// Memory / writeback stage: turns EX results into register writes, running a
// single bus transfer for loads and stores and flagging misaligned accesses.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        memRead_i,
    input  logic        memWrite_i,
    input  logic [1:0]  memSize_i,
    input  logic        memSigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] aluResult_i,
    input  logic        writeEnable_i,
    input  logic [4:0]  writeAddr_i,
    output logic        busReq_o,
    output logic        busWe_o,
    output logic [31:0] busAddr_o,
    output logic [3:0]  busBe_o,
    output logic [31:0] busWdata_o,
    input  logic [31:0] busRdata_i,
    input  logic        busAck_i,
    output logic        stall_o,
    output logic        regWriteEnable_o,
    output logic [4:0]  regWriteAddr_o,
    output logic [31:0] regWriteData_o,
    output logic        excAddrErr_o
);
    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t      r_state, w_next;
    logic        r_isLoad, r_signed, r_we;
    logic [1:0]  r_size, r_lane;
    logic [4:0]  r_wa;

    logic        w_memOp, w_isLoad, w_misal, w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_loadData;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_memOp  = memRead_i | memWrite_i;
    assign w_isLoad = memRead_i;    // read+write together behaves as a load
    assign w_misal  = (memSize_i == 2'b01 && addr_i[0]) ||
                      (memSize_i[1] && addr_i[1:0] != 2'b00);
    assign w_accept = (r_state == S_IDLE) && valid_i && w_memOp && !w_misal;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = storeData_i;
        if (!w_isLoad) begin
            case (memSize_i)
                2'b00: begin
                    w_be    = 4'b0001 << addr_i[1:0];
                    w_wdata = {4{storeData_i[7:0]}};
                end
                2'b01: begin
                    w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{storeData_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_byte     = busRdata_i[8*r_lane +: 8];
        w_half     = r_lane[1] ? busRdata_i[31:16] : busRdata_i[15:0];
        w_loadData = busRdata_i;
        case (r_size)
            2'b00:   w_loadData = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_loadData = {{16{r_signed & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUS;
            S_BUS:   if (busAck_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE:  stall_o = w_accept;
                S_BUS:   stall_o = !busAck_i;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busReq_o         <= 1'b0;
            busWe_o          <= 1'b0;
            busAddr_o        <= '0;
            busBe_o          <= '0;
            busWdata_o       <= '0;
            regWriteEnable_o <= 1'b0;
            regWriteAddr_o   <= '0;
            regWriteData_o   <= '0;
            excAddrErr_o     <= 1'b0;
            r_isLoad         <= 1'b0;
            r_signed         <= 1'b0;
            r_we             <= 1'b0;
            r_size           <= '0;
            r_lane           <= '0;
            r_wa             <= '0;
        end else begin
            regWriteEnable_o <= 1'b0;
            excAddrErr_o     <= 1'b0;
            if (r_state == S_IDLE) begin
                if (valid_i && w_memOp) begin
                    if (w_misal) begin
                        excAddrErr_o <= 1'b1;
                    end else begin
                        busReq_o   <= 1'b1;
                        busWe_o    <= !w_isLoad;
                        busAddr_o  <= {addr_i[31:2], 2'b00};
                        busBe_o    <= w_be;
                        busWdata_o <= w_wdata;
                        r_isLoad   <= w_isLoad;
                        r_signed   <= memSigned_i;
                        r_size     <= memSize_i;
                        r_lane     <= addr_i[1:0];
                        r_we       <= writeEnable_i;
                        r_wa       <= writeAddr_i;
                    end
                end else if (valid_i) begin
                    regWriteEnable_o <= writeEnable_i;
                    regWriteAddr_o   <= writeAddr_i;
                    regWriteData_o   <= aluResult_i;
                end
            end else if (busAck_i) begin
                busReq_o <= 1'b0;
                if (r_isLoad) begin
                    regWriteEnable_o <= r_we;
                    regWriteAddr_o   <= r_wa;
                    regWriteData_o   <= w_loadData;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a vector table for single-cycle ops plus
// hand sequences for bus transfers and reset during a transfer.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, memRead_i, memWrite_i, memSigned_i, writeEnable_i;
    logic [1:0]  memSize_i;
    logic [31:0] addr_i, storeData_i, aluResult_i, busRdata_i;
    logic [4:0]  writeAddr_i;
    logic        busAck_i;
    logic        busReq_o, busWe_o, stall_o, regWriteEnable_o, excAddrErr_o;
    logic [31:0] busAddr_o, busWdata_o, regWriteData_o;
    logic [3:0]  busBe_o;
    logic [4:0]  regWriteAddr_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .memRead_i(memRead_i),
        .memWrite_i(memWrite_i), .memSize_i(memSize_i), .memSigned_i(memSigned_i),
        .addr_i(addr_i), .storeData_i(storeData_i), .aluResult_i(aluResult_i),
        .writeEnable_i(writeEnable_i), .writeAddr_i(writeAddr_i),
        .busReq_o(busReq_o), .busWe_o(busWe_o), .busAddr_o(busAddr_o),
        .busBe_o(busBe_o), .busWdata_o(busWdata_o), .busRdata_i(busRdata_i),
        .busAck_i(busAck_i), .stall_o(stall_o), .regWriteEnable_o(regWriteEnable_o),
        .regWriteAddr_o(regWriteAddr_o), .regWriteData_o(regWriteData_o),
        .excAddrErr_o(excAddrErr_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_i = 0; memRead_i = 0; memWrite_i = 0; memSize_i = 0; memSigned_i = 0;
        addr_i = 0; storeData_i = 0; aluResult_i = 0; writeEnable_i = 0;
        writeAddr_i = 0; busAck_i = 0; busRdata_i = 0;
    endtask

    typedef struct {
        logic        valid, rd, wr, sgn, we;
        logic [1:0]  size;
        logic [31:0] addr, alu;
        logic [4:0]  wa;
        logic        e_rwe, e_exc, e_stall, e_req;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    // Memory-op sequence: accept, `waits` BUS cycles without ack, then ack.
    task automatic mem_op(input string nm, input logic rd, input logic wr,
                          input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                          input logic [31:0] sd, input logic we, input logic [4:0] wa,
                          input int waits, input logic [31:0] rdata,
                          input logic e_bwe, input logic [3:0] e_be, input logic [31:0] e_bwd,
                          input logic e_rwe, input logic [31:0] e_wd);
        @(negedge clk);
        valid_i = 1; memRead_i = rd; memWrite_i = wr; memSize_i = size; memSigned_i = sgn;
        addr_i = addr; storeData_i = sd; writeEnable_i = we; writeAddr_i = wa;
        aluResult_i = 32'hDEAD_BEEF; busAck_i = 0;
        #1 chk({nm, " accept stall"}, stall_o, 1);
        @(posedge clk); #1;
        chk({nm, " busReq"}, busReq_o, 1);
        chk({nm, " busWe"}, busWe_o, e_bwe);
        chk({nm, " busAddr"}, busAddr_o, {addr[31:2], 2'b00});
        chk({nm, " busBe"}, busBe_o, e_be);
        if (e_bwe) chk({nm, " busWdata"}, busWdata_o, e_bwd);
        chk({nm, " rwe at accept"}, regWriteEnable_o, 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk); busAck_i = 0; busRdata_i = 32'h0BAD_0BAD;
            #1 chk({nm, " wait stall"}, stall_o, 1);
            @(posedge clk); #1 chk({nm, " wait busReq"}, busReq_o, 1);
            chk({nm, " wait busBe"}, busBe_o, e_be);
        end
        @(negedge clk); busAck_i = 1; busRdata_i = rdata;
        #1 chk({nm, " ack stall"}, stall_o, 0);
        @(posedge clk); #1;
        chk({nm, " done busReq"}, busReq_o, 0);
        chk({nm, " done rwe"}, regWriteEnable_o, e_rwe);
        if (e_rwe) begin
            chk({nm, " done wa"}, regWriteAddr_o, wa);
            chk({nm, " done wd"}, regWriteData_o, e_wd);
        end
        @(negedge clk); idle_inputs();
        @(posedge clk); #1 chk({nm, " rwe one cycle"}, regWriteEnable_o, 0);
    endtask

    vec_t tbl[7];

    initial begin
        //        valid rd wr sgn we size   addr        alu          wa   rwe exc stl req wa  wd
        tbl[0] = '{1, 0, 0, 0, 1, 2'b10, 32'h0,     32'h1234,     5'd5, 1, 0, 0, 0, 5'd5, 32'h1234};
        tbl[1] = '{0, 0, 0, 0, 1, 2'b10, 32'h0,     32'h5555,     5'd9, 0, 0, 0, 0, 5'd5, 32'h1234};
        tbl[2] = '{1, 1, 0, 0, 1, 2'b10, 32'h301,   32'h0,        5'd3, 0, 1, 0, 0, 5'd5, 32'h1234};
        tbl[3] = '{1, 0, 0, 0, 1, 2'b00, 32'h0,     32'hCAFEF00D, 5'd31,1, 0, 0, 0, 5'd31,32'hCAFEF00D};
        tbl[4] = '{1, 1, 0, 1, 1, 2'b01, 32'h101,   32'h0,        5'd4, 0, 1, 0, 0, 5'd31,32'hCAFEF00D};
        tbl[5] = '{1, 0, 1, 0, 0, 2'b11, 32'h302,   32'h0,        5'd0, 0, 1, 0, 0, 5'd31,32'hCAFEF00D};
        tbl[6] = '{1, 0, 0, 0, 0, 2'b10, 32'h0,     32'h77,       5'd7, 0, 0, 0, 0, 5'd7, 32'h77};

        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", stall_o, 0);
        chk("reset busReq", busReq_o, 0);
        chk("reset busWe", busWe_o, 0);
        chk("reset busAddr", busAddr_o, 0);
        chk("reset busBe", busBe_o, 0);
        chk("reset busWdata", busWdata_o, 0);
        chk("reset rwe", regWriteEnable_o, 0);
        chk("reset rwa", regWriteAddr_o, 0);
        chk("reset rwd", regWriteData_o, 0);
        chk("reset exc", excAddrErr_o, 0);
        @(negedge clk); rst = 1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            valid_i = tbl[i].valid; memRead_i = tbl[i].rd; memWrite_i = tbl[i].wr;
            memSigned_i = tbl[i].sgn; writeEnable_i = tbl[i].we; memSize_i = tbl[i].size;
            addr_i = tbl[i].addr; aluResult_i = tbl[i].alu; writeAddr_i = tbl[i].wa;
            storeData_i = 32'h1111_2222;
            busAck_i = (i == 3); // stray ack in IDLE must be ignored
            #1 chk($sformatf("vec%0d stall", i), stall_o, tbl[i].e_stall);
            @(posedge clk); #1;
            chk($sformatf("vec%0d rwe", i), regWriteEnable_o, tbl[i].e_rwe);
            chk($sformatf("vec%0d exc", i), excAddrErr_o, tbl[i].e_exc);
            chk($sformatf("vec%0d busReq", i), busReq_o, tbl[i].e_req);
            chk($sformatf("vec%0d rwa", i), regWriteAddr_o, tbl[i].e_wa);
            chk($sformatf("vec%0d rwd", i), regWriteData_o, tbl[i].e_wd);
        end
        @(negedge clk); idle_inputs();
        @(posedge clk); #1 chk("exc one cycle", excAddrErr_o, 0);

        //     name     rd wr size  sgn addr      sd           we wa  wt rdata         bwe be       bwd           rwe wd
        mem_op("lb",    1, 0, 2'b00, 1, 32'h103, 32'h0,        1, 6,  2, 32'h80FFFFFF, 0, 4'b1111, 32'h0,        1, 32'hFFFFFF80);
        mem_op("sh",    0, 1, 2'b01, 0, 32'h202, 32'hABCD,     1, 8,  0, 32'h0,        1, 4'b1100, 32'hABCDABCD, 0, 32'h0);
        mem_op("lhu",   1, 0, 2'b01, 0, 32'h402, 32'h0,        1, 10, 0, 32'h9abc0000, 0, 4'b1111, 32'h0,        1, 32'h00009ABC);
        mem_op("sb",    0, 1, 2'b00, 0, 32'h101, 32'h1234565A, 0, 0,  1, 32'h0,        1, 4'b0010, 32'h5A5A5A5A, 0, 32'h0);
        mem_op("lbu",   1, 0, 2'b00, 0, 32'h001, 32'h0,        1, 11, 0, 32'h0000F000, 0, 4'b1111, 32'h0,        1, 32'h000000F0);
        mem_op("lh",    1, 0, 2'b01, 1, 32'h000, 32'h0,        1, 12, 1, 32'h00008001, 0, 4'b1111, 32'h0,        1, 32'hFFFF8001);
        mem_op("sw",    0, 1, 2'b10, 0, 32'h500, 32'hA5A55A5A, 0, 0,  0, 32'h0,        1, 4'b1111, 32'hA5A55A5A, 0, 32'h0);
        mem_op("rd+wr", 1, 1, 2'b10, 0, 32'h604, 32'h12345678, 1, 13, 0, 32'h87654321, 0, 4'b1111, 32'h0,        1, 32'h87654321);

        // Reset during a bus transfer with ack present
        @(negedge clk);
        valid_i = 1; memRead_i = 1; memSize_i = 2'b10; addr_i = 32'h300;
        writeEnable_i = 1; writeAddr_i = 5'd14;
        @(posedge clk); #1 chk("rstbus busReq up", busReq_o, 1);
        @(negedge clk); rst = 0; busAck_i = 1; busRdata_i = 32'h1357_9BDF;
        #1 chk("rstbus stall", stall_o, 0);
        @(posedge clk); #1;
        chk("rstbus busReq", busReq_o, 0);
        chk("rstbus rwe", regWriteEnable_o, 0);
        chk("rstbus rwd", regWriteData_o, 0);
        @(negedge clk); rst = 1; idle_inputs(); busAck_i = 1;
        @(posedge clk); #1 chk("rstbus post rwe", regWriteEnable_o, 0);
        chk("rstbus post busReq", busReq_o, 0);
        @(negedge clk); idle_inputs();
        valid_i = 1; writeEnable_i = 1; writeAddr_i = 5'd21; aluResult_i = 32'h0000_4242;
        #1 chk("after rst stall", stall_o, 0);
        @(posedge clk); #1;
        chk("after rst rwe", regWriteEnable_o, 1);
        chk("after rst rwa", regWriteAddr_o, 21);
        chk("after rst rwd", regWriteData_o, 32'h4242);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
